// File: rtl/alu_flag_branch_unit_pkg.sv
// Shared definitions for the flag/branch unit: condition codes, FSM states, flag bit order.
package alu_flag_branch_unit_pkg;

  typedef enum logic [3:0] {
    COND_AL = 4'd0,
    COND_EQ = 4'd1,
    COND_NE = 4'd2,
    COND_LT = 4'd3,
    COND_GE = 4'd4,
    COND_GT = 4'd5,
    COND_LE = 4'd6,
    COND_NV = 4'd7
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Flag vector is {N,Z}; the ALU drives its status in the same order.
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

endpackage

// File: rtl/alu_flag_branch_unit_branch_cond_eval.sv
// Combinational condition-code evaluator; codes 8-15 resolve as not taken.
module branch_cond_eval
  import alu_flag_branch_unit_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic       i_neg,
  input  logic       i_zero,
  output logic       o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      COND_AL: o_taken = 1'b1;
      COND_EQ: o_taken = i_zero;
      COND_NE: o_taken = ~i_zero;
      COND_LT: o_taken = i_neg;
      COND_GE: o_taken = ~i_neg;
      COND_GT: o_taken = ~i_neg & ~i_zero;
      COND_LE: o_taken = i_neg | i_zero;
      COND_NV: o_taken = 1'b0;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_flag_branch_unit.sv
// Architectural N/Z flag register, outstanding flag-writer scoreboard and branch resolver
// feeding taken/next-PC back to fetch.
module alu_flag_branch_unit
  import alu_flag_branch_unit_pkg::*;
#(
  parameter int PEND_W = 2,
  parameter int PC_INC = 4
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iFlagIssue,
  input  logic        iFlagWE,
  input  logic        iNEG,
  input  logic        iZERO,
  input  logic        iBrValid,
  output logic        oBrReady,
  input  logic [3:0]  iBrCond,
  input  logic [31:0] iBrPC,
  input  logic [31:0] iBrTarget,
  output logic        oResValid,
  input  logic        iResReady,
  output logic        oTaken,
  output logic [31:0] oNextPC,
  output logic [1:0]  oFlags,
  output logic        oPendErr,
  input  logic        iFlush
);

  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  state_e            r_state;
  state_e            w_state_next;
  logic [PEND_W-1:0] r_pend;
  logic [1:0]        r_flags;
  logic              r_pend_err;
  logic [3:0]        r_cond;
  logic [31:0]       r_pc;
  logic [31:0]       r_tgt;
  logic              r_taken;
  logic [31:0]       r_next_pc;

  logic [1:0]        w_eff_flags;
  logic              w_clear;
  logic              w_resolve;
  logic [3:0]        w_cond;
  logic [31:0]       w_pc;
  logic [31:0]       w_tgt;
  logic              w_taken;
  logic              w_pend_full;
  logic              w_pend_zero;

  assign w_pend_full = &r_pend;
  assign w_pend_zero = (r_pend == '0);
  // Writeback in the same cycle bypasses the register so a branch never sees stale flags.
  assign w_eff_flags = iFlagWE ? {iNEG, iZERO} : r_flags;
  assign w_clear     = w_pend_zero || ((r_pend == PEND_ONE) && iFlagWE && !iFlagIssue);

  always_comb begin
    w_state_next = r_state;
    w_resolve    = 1'b0;
    w_cond       = r_cond;
    w_pc         = r_pc;
    w_tgt        = r_tgt;
    case (r_state)
      ST_IDLE: begin
        w_cond = iBrCond;
        w_pc   = iBrPC;
        w_tgt  = iBrTarget;
        if (iBrValid) begin
          if (w_clear) begin
            w_resolve    = 1'b1;
            w_state_next = ST_RESP;
          end else begin
            w_state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (w_clear) begin
          w_resolve    = 1'b1;
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (iResReady) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  branch_cond_eval u_cond_eval (
    .i_cond  (w_cond),
    .i_neg   (w_eff_flags[FLAG_N]),
    .i_zero  (w_eff_flags[FLAG_Z]),
    .o_taken (w_taken)
  );

  // Flags are architectural state: written on every writeback, untouched by flush.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) r_flags <= 2'b00;
    else if (iFlagWE) r_flags <= {iNEG, iZERO};
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state    <= ST_IDLE;
      r_pend     <= '0;
      r_pend_err <= 1'b0;
      r_cond     <= 4'd0;
      r_pc       <= 32'd0;
      r_tgt      <= 32'd0;
      r_taken    <= 1'b0;
      r_next_pc  <= 32'd0;
    end else if (iFlush) begin
      r_state <= ST_IDLE;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_next;
      case ({iFlagIssue, iFlagWE})
        2'b10: begin
          if (w_pend_full) r_pend_err <= 1'b1;
          else r_pend <= r_pend + PEND_ONE;
        end
        2'b01: begin
          if (w_pend_zero) r_pend_err <= 1'b1;
          else r_pend <= r_pend - PEND_ONE;
        end
        default: r_pend <= r_pend;
      endcase
      if (r_state == ST_IDLE && iBrValid) begin
        r_cond <= iBrCond;
        r_pc   <= iBrPC;
        r_tgt  <= iBrTarget;
      end
      if (w_resolve) begin
        r_taken   <= w_taken;
        r_next_pc <= w_taken ? w_tgt : (w_pc + 32'(PC_INC));
      end
    end
  end

  assign oBrReady  = (r_state == ST_IDLE);
  assign oResValid = (r_state == ST_RESP);
  assign oTaken    = r_taken;
  assign oNextPC   = r_next_pc;
  assign oFlags    = r_flags;
  assign oPendErr  = r_pend_err;

endmodule

// File: tb/tb_alu_flag_branch_unit.sv
// Directed bench for alu_flag_branch_unit with hand-computed expectations.
module tb_alu_flag_branch_unit;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic        iFlagIssue, iFlagWE, iNEG, iZERO;
  logic        iBrValid, oBrReady;
  logic [3:0]  iBrCond;
  logic [31:0] iBrPC, iBrTarget;
  logic        oResValid, iResReady, oTaken;
  logic [31:0] oNextPC;
  logic [1:0]  oFlags;
  logic        oPendErr, iFlush;

  int n_checks = 0;
  int n_errors = 0;

  alu_flag_branch_unit #(.PEND_W(2), .PC_INC(4)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iFlagIssue(iFlagIssue), .iFlagWE(iFlagWE),
    .iNEG(iNEG), .iZERO(iZERO), .iBrValid(iBrValid), .oBrReady(oBrReady),
    .iBrCond(iBrCond), .iBrPC(iBrPC), .iBrTarget(iBrTarget), .oResValid(oResValid),
    .iResReady(iResReady), .oTaken(oTaken), .oNextPC(oNextPC), .oFlags(oFlags),
    .oPendErr(oPendErr), .iFlush(iFlush)
  );

  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic branch(input logic [3:0] cond, input logic [31:0] pc, input logic [31:0] tgt);
    iBrValid  = 1'b1;
    iBrCond   = cond;
    iBrPC     = pc;
    iBrTarget = tgt;
  endtask

  task automatic release_resp();
    iResReady = 1'b1;
    tick();
    iResReady = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic taken, input logic [31:0] npc);
    chk({tag, "_valid"}, oResValid, 1'b1);
    chk({tag, "_taken"}, oTaken, taken);
    chk({tag, "_npc"}, oNextPC, npc);
  endtask

  initial begin
    iRst_n = 1'b0; iFlagIssue = 0; iFlagWE = 0; iNEG = 0; iZERO = 0;
    iBrValid = 0; iBrCond = 0; iBrPC = 0; iBrTarget = 0; iResReady = 0; iFlush = 0;
    #3;
    chk("rst_ready", oBrReady, 1'b1);
    chk("rst_valid", oResValid, 1'b0);
    chk("rst_taken", oTaken, 1'b0);
    chk("rst_npc", oNextPC, 32'h0);
    chk("rst_flags", oFlags, 2'b00);
    chk("rst_perr", oPendErr, 1'b0);
    tick(); tick();
    iRst_n = 1'b1;

    // Set Z=1 through a balanced issue/writeback pair.
    iFlagIssue = 1; tick(); iFlagIssue = 0;
    iFlagWE = 1; iNEG = 0; iZERO = 1; tick(); iFlagWE = 0;
    chk("setz_flags", oFlags, 2'b01);
    chk("setz_perr", oPendErr, 1'b0);

    // EQ with Z=1, no pending -> resolved after one edge.
    branch(4'd1, 32'h100, 32'h200); tick(); iBrValid = 0;
    chk_res("eq", 1'b1, 32'h200);
    chk("eq_ready", oBrReady, 1'b0);
    release_resp();
    chk("eq_rel_valid", oResValid, 1'b0);
    chk("eq_rel_ready", oBrReady, 1'b1);

    // LT waits for an outstanding writer, then resolves on bypassed N=1.
    iFlagIssue = 1; tick(); iFlagIssue = 0;
    branch(4'd3, 32'h300, 32'h400); tick(); iBrValid = 0;
    chk("lt_wait_valid", oResValid, 1'b0);
    chk("lt_wait_ready", oBrReady, 1'b0);
    tick(); tick();
    chk("lt_wait2_valid", oResValid, 1'b0);
    iFlagWE = 1; iNEG = 1; iZERO = 0; tick(); iFlagWE = 0;
    chk_res("lt", 1'b1, 32'h400);
    chk("lt_flags", oFlags, 2'b10);
    release_resp();

    // NE not taken via same-cycle bypass Z=1; fall-through wraps to 0.
    iFlagIssue = 1; tick(); iFlagIssue = 0;
    iFlagWE = 1; iNEG = 0; iZERO = 1;
    branch(4'd2, 32'hFFFF_FFFC, 32'h1000); tick(); iBrValid = 0; iFlagWE = 0;
    chk_res("ne_wrap", 1'b0, 32'h0);
    chk("ne_flags", oFlags, 2'b01);
    release_resp();

    // Fill counter to 3, overflow attempt sets error without wrapping.
    iFlagIssue = 1; tick(); tick(); tick();
    chk("full_perr0", oPendErr, 1'b0);
    tick(); iFlagIssue = 0;
    chk("ovf_perr", oPendErr, 1'b1);
    iFlagWE = 1; iNEG = 0; iZERO = 0; tick(); tick(); iFlagWE = 0;
    branch(4'd0, 32'h2000, 32'h3000); tick(); iBrValid = 0;
    chk("ovf_still_pend", oResValid, 1'b0);
    iFlagWE = 1; tick(); iFlagWE = 0;
    chk_res("al", 1'b1, 32'h3000);
    release_resp();
    iFlagWE = 1; iNEG = 1; iZERO = 1; tick(); iFlagWE = 0;
    chk("udf_perr", oPendErr, 1'b1);
    chk("udf_flags", oFlags, 2'b11);

    // GE with N=1 not taken; response held while fetch stalls.
    branch(4'd4, 32'h500, 32'h600); tick(); iBrValid = 0;
    for (int i = 0; i < 5; i++) begin
      chk_res("hold", 1'b0, 32'h504);
      chk("hold_ready", oBrReady, 1'b0);
      tick();
    end
    iResReady = 1;
    branch(4'd7, 32'h700, 32'h800); tick(); iResReady = 0;
    chk("hs_valid", oResValid, 1'b0);
    chk("hs_ready", oBrReady, 1'b1);
    tick(); iBrValid = 0;
    chk_res("nv", 1'b0, 32'h704);
    release_resp();

    // Flush out of WAIT with two pending; next branch sees an empty scoreboard.
    iFlagIssue = 1; tick(); tick(); iFlagIssue = 0;
    branch(4'd0, 32'h10, 32'h20); tick(); iBrValid = 0;
    chk("fl_wait_valid", oResValid, 1'b0);
    iFlush = 1; tick(); iFlush = 0;
    chk("fl_ready", oBrReady, 1'b1);
    chk("fl_valid", oResValid, 1'b0);
    branch(4'd5, 32'h800, 32'h900); tick(); iBrValid = 0;
    chk_res("gt", 1'b0, 32'h804);
    chk("fl_flags", oFlags, 2'b11);
    chk("fl_perr", oPendErr, 1'b1);
    release_resp();

    branch(4'd6, 32'hC00, 32'hD00); tick(); iBrValid = 0;
    chk_res("le", 1'b1, 32'hD00);
    release_resp();

    // Illegal code 9, then asynchronous reset while the response is held.
    branch(4'd9, 32'hA00, 32'hB00); tick(); iBrValid = 0;
    chk_res("ill", 1'b0, 32'hA04);
    #2 iRst_n = 1'b0;
    #1;
    chk("arst_valid", oResValid, 1'b0);
    chk("arst_ready", oBrReady, 1'b1);
    chk("arst_flags", oFlags, 2'b00);
    chk("arst_perr", oPendErr, 1'b0);
    chk("arst_npc", oNextPC, 32'h0);
    chk("arst_taken", oTaken, 1'b0);
    tick();
    iRst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
